truth_table_capture: RTL and testbench
======================================

# truth_table_capture

On-board self-test sequencer for the 4-switch/1-LED logic blocks. On `start` it walks every input code from 0 to 2^IN_WIDTH−1 on `dut_in`, waits a settle interval, and samples the single-bit `dut_out` into a captured truth table. It then compares the table against a parameterized expected vector and reports pass/fail and the mismatch count. It sits between the board switch/button logic and the combinational unit under test, and replaces the simulation-only sweep with a synthesizable one.

## Interface
- `IN_WIDTH`, default 4: DUT input width; the table is 2^IN_WIDTH bits (TW).
- `SETTLE_CYCLES`, default 4: clocks each code is held before sampling; legal range is 1 and up.
- `EXPECTED`, default 16'h0000: golden truth table, TW bits; bit i is the expected `dut_out` for code i.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begins a sweep; sampled only in IDLE.
- `dut_in` out IN_WIDTH: code driven to the DUT.
- `dut_out` in 1: DUT response; combinational in the `clk` domain; no synchronizer.
- `busy` out 1: high from the cycle after `start` is accepted through the last SAMPLE.
- `done` out 1: one-cycle pulse when results are valid.
- `table_out` out TW: captured truth table.
- `mismatch_count` out IN_WIDTH+1: number of bits where `table_out` and `EXPECTED` differ.
- `pass` out 1: high when `mismatch_count` is 0; valid from `done` onward.

## Operation
- States and transitions:
  - IDLE: go to SETTLE if `start` is high.
  - SETTLE: count 0..SETTLE_CYCLES−1, then go to SAMPLE.
  - SAMPLE: one cycle. Go to SETTLE if code < TW−1, otherwise go to DONE.
  - DONE: one cycle, then go to IDLE.
- Accepting `start` in IDLE:
  - sets code = 0 and settle count = 0;
  - clears `table_out`, `mismatch_count` and `pass`.
- SAMPLE:
  - writes `table_out[code] <= dut_out`;
  - increments `mismatch_count` if `dut_out != EXPECTED[code]`;
  - increments code if code < TW−1.
- `dut_in` equals the registered code in every state. It returns to 0 on entry to IDLE from DONE.
- DONE:
  - `done` = 1;
  - `pass` is registered as (`mismatch_count` == 0), using the final count including the last SAMPLE.
- `table_out`, `mismatch_count` and `pass` hold their values in IDLE until the next accepted `start`.
- `start` in any state other than IDLE is ignored. It is level-sensitive: if `start` is still high in IDLE after DONE, a new sweep begins immediately.
- Reset values (asynchronous, on `rst_n` low): state = IDLE, `dut_in` = 0, `busy` = 0, `done` = 0, `table_out` = 0, `mismatch_count` = 0, `pass` = 0.
- Reset mid-sweep aborts immediately to the reset values. No `done` pulse is produced.
- Width rule: `mismatch_count` can reach TW (16 with defaults). It is IN_WIDTH+1 bits wide, so it never wraps.

## Timing
- `start` sampled high at rising edge E0:
  - SETTLE for code 0 begins at E0+1;
  - code c is driven on `dut_in` from E0+1+c·(SETTLE_CYCLES+1);
  - `dut_out` is sampled SETTLE_CYCLES cycles after code c appears.
- `done` is high in the cycle starting at E0+1+TW·(SETTLE_CYCLES+1). With defaults this is E0+81.
- `busy` is 0 in IDLE and DONE, and 1 in SETTLE and SAMPLE.
- Total sweep latency: TW·(SETTLE_CYCLES+1)+1 cycles, from `start` acceptance to `done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `tt_pkg`:
  - state encoding localparams (IDLE, SETTLE, SAMPLE, DONE);
  - TW derivation, as 1 << IN_WIDTH.
- Sub-module `tt_settle_timer`:
  - parameter SETTLE_CYCLES;
  - inputs `clk`, `rst_n`, `load`;
  - output `expired`, one cycle after the count reaches SETTLE_CYCLES−1.
- The top level holds the FSM, code counter, table register and mismatch accumulator.

## Test plan
- Reset, then idle for 10 cycles: all outputs stay at 0, and `start` pulses during reset are ignored.
- DUT model `led = (sw == 4'b1010)`, EXPECTED = 16'h0400, one `start` pulse:
  - `done` arrives exactly 81 cycles after `start`;
  - `table_out` = 16'h0400, `mismatch_count` = 0, `pass` = 1.
- Same DUT model with EXPECTED = 16'h0401:
  - `table_out` = 16'h0400, `mismatch_count` = 1, `pass` = 0.
- DUT model tied to 1, EXPECTED = 16'h0000:
  - `table_out` = 16'hFFFF, `mismatch_count` = 16, `pass` = 0 (checks the count does not wrap).
- `start` re-pulsed at cycle 20 of a sweep: ignored, and `done` still arrives at cycle 81. Then `rst_n` is pulled low at cycle 40 of a second sweep:
  - all outputs return to 0 within the same cycle;
  - no `done` pulse appears.
- SETTLE_CYCLES = 1 with a registered DUT model of 1-cycle latency: `done` at E0+33, and the table matches the model.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table capture sequencer: state encoding and
// table-width derivation.
package tt_pkg;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_SETTLE = 2'd1;
  localparam logic [1:0] ENC_SAMPLE = 2'd2;
  localparam logic [1:0] ENC_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ENC_IDLE,
    SETTLE = ENC_SETTLE,
    SAMPLE = ENC_SAMPLE,
    DONE   = ENC_DONE
  } tt_state_e;

  function automatic int tw_of(input int in_width);
    return 1 << in_width;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-interval timer: restarts on load, raises expired once the count has
// reached SETTLE_CYCLES-1 and holds it until the next load.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  // A single-cycle interval is already expired the moment it is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      expired <= (LAST == '0);
    end else if (!expired) begin
      cnt     <= cnt_inc;
      expired <= (cnt_inc == LAST);
    end
  end

endmodule

// File: rtl/truth_table_capture.sv
// Self-test sweep: drives every input code, lets it settle, samples the
// response into a table and scores it against the golden EXPECTED vector.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int IN_WIDTH      = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [tw_of(IN_WIDTH)-1:0] EXPECTED = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [IN_WIDTH-1:0]         dut_in,
  input  logic                        dut_out,
  output logic                        busy,
  output logic                        done,
  output logic [tw_of(IN_WIDTH)-1:0]  table_out,
  output logic [IN_WIDTH:0]           mismatch_count,
  output logic                        pass
);

  localparam int TW = tw_of(IN_WIDTH);
  localparam logic [IN_WIDTH-1:0] LAST_CODE = IN_WIDTH'(TW - 1);

  tt_state_e          state;
  tt_state_e          state_nxt;
  logic               load;
  logic               expired;
  logic               last;
  logic               miss;
  logic [IN_WIDTH:0]  mm_nxt;

  assign last   = (dut_in == LAST_CODE);
  assign miss   = dut_out ^ EXPECTED[dut_in];
  assign mm_nxt = mismatch_count + {{IN_WIDTH{1'b0}}, miss};
  assign load   = ((state == IDLE) && start) || (state == SAMPLE);

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (expired) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they stay registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SETTLE) || (state_nxt == SAMPLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            dut_in         <= '0;
            table_out      <= '0;
            mismatch_count <= '0;
            pass           <= 1'b0;
          end
        end
        SAMPLE: begin
          table_out[dut_in] <= dut_out;
          mismatch_count    <= mm_nxt;
          // pass uses the count including this last sample so it is valid with done.
          if (last) pass   <= (mm_nxt == '0);
          else      dut_in <= dut_in + IN_WIDTH'(1);
        end
        DONE:    dut_in <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: directed sweeps against simple unit models
// plus randomized response tables scored by a table-level reference model.
module tb_truth_table_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_d = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  localparam logic [15:0] EXP_A = 16'h0400;
  localparam logic [15:0] EXP_B = 16'h0401;
  localparam logic [15:0] EXP_C = 16'h0000;
  localparam logic [15:0] EXP_R = 16'hA5C3;
  localparam logic [15:0] EXP_D = 16'h9249;

  logic [3:0]  in_a, in_b, in_c, in_r, in_d;
  logic        out_a, out_b, out_c, out_r;
  logic        out_d = 1'b0;
  logic        busy_a, busy_b, busy_c, busy_r, busy_d;
  logic        done_a, done_b, done_c, done_r, done_d;
  logic        pass_a, pass_b, pass_c, pass_r, pass_d;
  logic [15:0] tbl_a, tbl_b, tbl_c, tbl_r, tbl_d;
  logic [4:0]  mm_a, mm_b, mm_c, mm_r, mm_d;
  logic [15:0] rnd_tbl = 16'h0;

  assign out_a = (in_a == 4'b1010);
  assign out_b = (in_b == 4'b1010);
  assign out_c = 1'b1;
  assign out_r = rnd_tbl[in_r];
  always @(posedge clk) out_d <= ((int'(in_d) % 3) == 0);

  truth_table_capture #(.IN_WIDTH(4), .SETTLE_CYCLES(4), .EXPECTED(EXP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(in_a), .dut_out(out_a),
    .busy(busy_a), .done(done_a), .table_out(tbl_a), .mismatch_count(mm_a), .pass(pass_a));
  truth_table_capture #(.IN_WIDTH(4), .SETTLE_CYCLES(4), .EXPECTED(EXP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(in_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .table_out(tbl_b), .mismatch_count(mm_b), .pass(pass_b));
  truth_table_capture #(.IN_WIDTH(4), .SETTLE_CYCLES(4), .EXPECTED(EXP_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(in_c), .dut_out(out_c),
    .busy(busy_c), .done(done_c), .table_out(tbl_c), .mismatch_count(mm_c), .pass(pass_c));
  truth_table_capture #(.IN_WIDTH(4), .SETTLE_CYCLES(4), .EXPECTED(EXP_R)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(in_r), .dut_out(out_r),
    .busy(busy_r), .done(done_r), .table_out(tbl_r), .mismatch_count(mm_r), .pass(pass_r));
  truth_table_capture #(.IN_WIDTH(4), .SETTLE_CYCLES(1), .EXPECTED(EXP_D)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .dut_in(in_d), .dut_out(out_d),
    .busy(busy_d), .done(done_d), .table_out(tbl_d), .mismatch_count(mm_d), .pass(pass_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Pulses start (or start_d) and returns cycles from the start cycle to done.
  task automatic sweep(input bit on_d, input int repulse, output int lat);
    int s;
    lat = -1;
    @(negedge clk);
    if (on_d) start_d = 1'b1;
    else      start   = 1'b1;
    s = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start   = !on_d && ((cyc - s) == repulse);
      start_d = 1'b0;
      if (on_d ? done_d : done_a) begin
        lat = cyc - s;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          lat;
  int          s0;
  logic        seen;
  logic [15:0] ref_tbl;
  int          ref_mm;

  initial begin
    // Reset with start pulses that must be ignored, then idle
    repeat (2) @(negedge clk);
    start = 1'b1; start_d = 1'b1;
    @(negedge clk);
    start = 1'b0; start_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_a", {4'h0, in_a, busy_a, done_a, tbl_a, mm_a, pass_a}, 32'h0);
      chk("idle_d", {4'h0, in_d, busy_d, done_d, tbl_d, mm_d, pass_d}, 32'h0);
    end

    // Directed sweep: a, b, c run together
    rnd_tbl = 16'h1234;
    sweep(1'b0, 0, lat);
    chk("lat_a", lat, 81);
    chk("done_b", done_b, 1'b1);
    chk("done_c", done_c, 1'b1);
    chk("busy_in_done", busy_a, 1'b0);
    chk("tbl_a", tbl_a, 16'h0400);
    chk("mm_a", mm_a, 0);
    chk("pass_a", pass_a, 1'b1);
    chk("tbl_b", tbl_b, 16'h0400);
    chk("mm_b", mm_b, 1);
    chk("pass_b", pass_b, 1'b0);
    chk("tbl_c", tbl_c, 16'hFFFF);
    chk("mm_c_nowrap", mm_c, 16);
    chk("pass_c", pass_c, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", done_a, 1'b0);
    chk("dut_in_back_to_0", in_a, 0);
    chk("hold_tbl_a", tbl_a, 16'h0400);
    chk("hold_pass_a", pass_a, 1'b1);

    // start re-pulsed mid-sweep is ignored
    sweep(1'b0, 20, lat);
    chk("lat_repulse", lat, 81);
    chk("tbl_repulse", tbl_a, 16'h0400);
    @(negedge clk);
    chk("no_restart", busy_a, 1'b0);

    // Reset at cycle 40 of a sweep aborts without done
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && (cyc - s0) < 40; i++) @(negedge clk);
    chk("busy_mid_sweep", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_a", {4'h0, in_a, busy_a, done_a, tbl_a, mm_a, pass_a}, 32'h0);
    chk("abort_c", {4'h0, in_c, busy_c, done_c, tbl_c, mm_c, pass_c}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      seen = seen | done_a | done_b | done_c | done_r;
    end
    chk("no_done_after_abort", seen, 1'b0);
    chk("idle_after_abort", {4'h0, in_a, busy_a, done_a, tbl_a, mm_a, pass_a}, 32'h0);

    // Randomized response tables against the reference scorer
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      rnd_tbl = EXP_R;
      else if (k == 1) rnd_tbl = ~EXP_R;
      else             rnd_tbl = 16'($urandom);
      ref_tbl = rnd_tbl;
      ref_mm  = $countones(rnd_tbl ^ EXP_R);
      sweep(1'b0, 0, lat);
      chk("lat_r", lat, 81);
      chk("done_r", done_r, 1'b1);
      chk("tbl_r", tbl_r, ref_tbl);
      chk("mm_r", mm_r, ref_mm);
      chk("pass_r", pass_r, ref_mm == 0);
    end

    // SETTLE_CYCLES = 1 with a registered unit model
    ref_tbl = '0;
    for (int c = 0; c < 16; c++) ref_tbl[c] = ((c % 3) == 0);
    ref_mm = $countones(ref_tbl ^ EXP_D);
    sweep(1'b1, 0, lat);
    chk("lat_d", lat, 33);
    chk("tbl_d", tbl_d, ref_tbl);
    chk("mm_d", mm_d, ref_mm);
    chk("pass_d", pass_d, ref_mm == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
